// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: the requester drives
// start/a/b, the subtractor returns status and the held result.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             ovf;

   modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
   modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, one-cycle done pulse.
// Define SERIAL_SUB_OVF_EN to register signed overflow on ovf; otherwise ovf is 0.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   serial_subtractor_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam int         CW      = $clog2(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d, bout_q, bout_d;
   logic             ai, bi, res, br_nx, last, accept;

   assign ai     = a_q[0];
   assign bi     = b_q[0];
   assign res    = ai ^ bi ^ br_q;
   assign br_nx  = (~ai & bi) | (~(ai ^ bi) & br_q);
   assign last   = (cnt_q == CW'(WIDTH - 1));
   assign accept = (state_q == S_IDLE) && bus.start;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               diff_d  = '0;
               cnt_d   = '0;
               br_d    = 1'b0;
               bout_d  = 1'b0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
            diff_d = {res, diff_q[WIDTH-1:1]};
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            br_d   = br_nx;
            cnt_d  = cnt_q + CW'(1);
            if (last) begin
               bout_d  = br_nx;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
      end
   end

   assign bus.busy       = (state_q == S_SHIFT);
   assign bus.done       = (state_q == S_DONE);
   assign bus.diff       = diff_q;
   assign bus.borrow_out = bout_q;

`ifdef SERIAL_SUB_OVF_EN
   logic ovf_q, ovf_d;

   // Signed overflow: borrow into the sign bit differs from borrow out of it.
   always_comb begin
      ovf_d = ovf_q;
      if (accept)
         ovf_d = 1'b0;
      else if ((state_q == S_SHIFT) && last)
         ovf_d = br_q ^ br_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif
endmodule
